// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem
// Description : Word-addressed instruction memory with a combinational fetch
//               port, a synchronous load port and a sticky write-protect lock.
//               Optional even-parity protection is enabled by IM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lock,
  output logic              locked,
`ifdef IM_PARITY_EN
  output logic              par_err,
`endif
  output logic              wr_reject
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] IM [0:c_DEPTH-1];
  logic              r_locked;
  logic              r_wr_reject;
  logic              w_wr_en;

  assign w_wr_en = we & ~r_locked;

`ifdef IM_PARITY_EN
  logic r_par [0:c_DEPTH-1];
`endif

  // Contents deliberately survive reset; reset only suppresses writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (w_wr_en) begin
      IM[waddr]    <= wdata;
`ifdef IM_PARITY_EN
      r_par[waddr] <= ^wdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked    <= 1'b0;
      r_wr_reject <= 1'b0;
    end else begin
      if (lock) begin
        r_locked <= 1'b1;
      end
      r_wr_reject <= we & r_locked;
    end
  end

  assign rd        = IM[address];
  assign locked    = r_locked;
  assign wr_reject = r_wr_reject;

`ifdef IM_PARITY_EN
  assign par_err = (^IM[address]) ^ r_par[address];
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem
// Description : Scoreboard-driven self-checking bench for instr_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam int c_SEL_RD  = 0;
  localparam int c_SEL_LCK = 1;
  localparam int c_SEL_REJ = 2;
  localparam int c_SEL_PAR = 3;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] rd;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              locked;
  logic              wr_reject;
`ifdef IM_PARITY_EN
  logic              par_err;
`endif

  instr_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .rd        (rd),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .lock      (lock),
    .locked    (locked),
`ifdef IM_PARITY_EN
    .par_err   (par_err),
`endif
    .wr_reject (wr_reject)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      c_SEL_RD:  return rd;
      c_SEL_LCK: return {31'd0, locked};
      c_SEL_REJ: return {31'd0, wr_reject};
`ifdef IM_PARITY_EN
      c_SEL_PAR: return {31'd0, par_err};
`endif
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  logic [31:0] pre [0:2];

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pre[0] = 32'h0123_4567;
    pre[1] = 32'h0123_4333;
    pre[2] = 32'h0123_4569;

    rst_n   = 1'b0;
    we      = 1'b0;
    lock    = 1'b0;
    waddr   = '0;
    wdata   = '0;
    address = '0;
    for (int i = 0; i < 3; i++) dut.IM[i] = pre[i];
    dut.IM[5]  = 32'h0000_0055;
    dut.IM[31] = 32'hCAFE_F00D;

    // Reset state and combinational reads, no edge involved.
    #2;
    push("rst_locked", c_SEL_LCK, 32'd0);
    push("rst_wr_reject", c_SEL_REJ, 32'd0);
    drain();
    for (int i = 0; i < 3; i++) begin
      address = 5'(i);
      push($sformatf("preload_rd%0d", i), c_SEL_RD, pre[i]);
      #1;
      drain();
    end

    // Preloads survive reset release.
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      address = 5'(i);
      push($sformatf("post_reset_rd%0d", i), c_SEL_RD, pre[i]);
      #1;
      drain();
    end

    // Read-during-write on word 31.
    @(negedge clk);
    address = 5'd31;
    we      = 1'b1;
    waddr   = 5'd31;
    wdata   = 32'hDEAD_BEEF;
    push("rdw_old", c_SEL_RD, 32'hCAFE_F00D);
    #1;
    drain();
    @(posedge clk) #1;
    we = 1'b0;
    push("rdw_new", c_SEL_RD, 32'hDEAD_BEEF);
    drain();

    // Lock, then a rejected write.
    @(negedge clk) lock = 1'b1;
    @(posedge clk) #1;
    lock = 1'b0;
    push("lock_set", c_SEL_LCK, 32'd1);
    drain();
    @(negedge clk);
    we      = 1'b1;
    waddr   = 5'd0;
    wdata   = 32'h0;
    address = 5'd0;
    @(posedge clk) #1;
    we = 1'b0;
    push("reject_pulse", c_SEL_REJ, 32'd1);
    push("still_locked", c_SEL_LCK, 32'd1);
    push("protected_rd", c_SEL_RD, pre[0]);
    drain();
    @(posedge clk) #1;
    push("reject_clear", c_SEL_REJ, 32'd0);
    drain();

    // Mid-cycle asynchronous reset clears lock and reject with no edge.
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd0;
    @(posedge clk) #1;
    we = 1'b0;
    push("reject_before_rst", c_SEL_REJ, 32'd1);
    drain();
    #2 rst_n = 1'b0;
    #1;
    push("async_rst_locked", c_SEL_LCK, 32'd0);
    push("async_rst_reject", c_SEL_REJ, 32'd0);
    drain();

    // Writes are ignored while in reset.
    @(negedge clk);
    we      = 1'b1;
    waddr   = 5'd5;
    wdata   = 32'hFFFF_0000;
    address = 5'd5;
    @(posedge clk) #1;
    we = 1'b0;
    push("write_in_reset", c_SEL_RD, 32'h0000_0055);
    drain();

    // Simultaneous lock and write while unlocked: write lands, then lock.
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    we      = 1'b1;
    lock    = 1'b1;
    waddr   = 5'd0;
    wdata   = 32'hA5A5_A5A5;
    address = 5'd0;
    @(posedge clk) #1;
    we   = 1'b0;
    lock = 1'b0;
    push("lock_we_write", c_SEL_RD, 32'hA5A5_A5A5);
    push("lock_we_locked", c_SEL_LCK, 32'd1);
    push("lock_we_noreject", c_SEL_REJ, 32'd0);
    drain();

`ifdef IM_PARITY_EN
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd4;
    wdata = 32'h0000_0001;
    @(negedge clk);
    waddr = 5'd6;
    wdata = 32'h0000_0003;
    @(negedge clk);
    we      = 1'b0;
    address = 5'd4;
    push("par_ok4", c_SEL_PAR, 32'd0);
    #1;
    drain();
    address = 5'd6;
    push("par_ok6", c_SEL_PAR, 32'd0);
    #1;
    drain();
    dut.IM[4] = 32'h0000_0003;
    address   = 5'd4;
    push("par_err4", c_SEL_PAR, 32'd1);
    #1;
    drain();
    address = 5'd6;
    push("par_ok6_after", c_SEL_PAR, 32'd0);
    #1;
    drain();
`endif

    if (sb.size() != 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem.md
Name: instr_mem

Overview:
- Word-addressed instruction memory for the RISC-V core. Holds 2**ADDR_W words of DATA_W bits.
- The fetch path reads it through a purely combinational port: fetch address in, instruction out in the same cycle.
- A synchronous load port fills the program before execution. A sticky lock write-protects the program until reset.

Parameters:
- ADDR_W, 5, word-address width; depth is 2**ADDR_W (32 words).
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock; all writes and state updates occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  fetch word index (not a byte address).
- rd  output  DATA_W  instruction word at address.
- we  input  1  load-port write enable.
- waddr  input  ADDR_W  load-port word index.
- wdata  input  DATA_W  load-port data.
- lock  input  1  one-cycle pulse; sets the write-protect latch.
- locked  output  1  write-protect latch state.
- wr_reject  output  1  registered; high for one cycle after a write was attempted while locked.

Behaviour:
- Storage is an unpacked array named IM, indexed 0..2**ADDR_W-1. The name is fixed because benches preload it hierarchically (IM[n] = value).
- Read path:
  - rd = IM[address] combinationally, with zero latency and no clock involvement.
  - rd changes within the same simulation delta when address or the addressed word changes.
- Every ADDR_W-bit address is in range, so there is no wrap logic. Words never written or preloaded read X in simulation.
- Write path:
  - On posedge clk, if we=1 and locked=0, then IM[waddr] <= wdata.
  - Read-during-write to the same word: rd shows the old word until the edge and the new word immediately after.
- Lock:
  - On posedge clk, lock=1 sets locked to 1. locked stays 1 until reset.
  - If we=1 and locked=1 at an edge, no write occurs and wr_reject is 1 for the following cycle. Otherwise wr_reject is 0.
  - If lock and we are both 1 at the same edge with locked=0, the write completes and locked rises after that edge.
- Reset (rst_n=0, asynchronous):
  - locked=0 and wr_reject=0 immediately.
  - IM contents are NOT cleared or altered by reset, so hierarchical preloads survive reset.
  - Writes are ignored while rst_n=0.
- Deassertion of rst_n is not synchronised internally; it is the system's responsibility.

Optional Feature:
- Macro: IM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from wdata on every load-port write.
  - Adds output par_err (1 bit, combinational): high when the parity of IM[address] disagrees with its stored parity bit.
  - Words preloaded hierarchically without parity set par_err=X/undefined. Benches preload only through the load port when this is enabled.
- Undefined:
  - No parity storage and no par_err port; behaviour is otherwise identical.

Test Plan:
- Preload IM[0]=32'h01234567, IM[1]=32'h01234333, IM[2]=32'h01234569 hierarchically. Set address=0 → rd=32'h01234567 with no clock edge; address=1 → rd=32'h01234333; address=2 → rd=32'h01234569.
- Hold rst_n=0, then release it; IM[0..2] still read back the preloaded values.
- Write we=1, waddr=31, wdata=32'hDEADBEEF with address=31: rd is the old value before the edge and 32'hDEADBEEF after it.
- Pulse lock, then write we=1, waddr=0, wdata=32'h0 → IM[0] stays 32'h01234567, wr_reject=1 for one cycle, locked=1.
- Assert rst_n=0 mid-cycle while locked=1 → locked and wr_reject go 0 immediately without a clock. A subsequent write to waddr=0 succeeds.
- With IM_PARITY_EN defined: write 32'h00000001 to word 4, then force a flipped bit in IM[4] → par_err=1 at address=4; par_err=0 for an unmodified written word.
